// File: rtl/alu_result_stage.sv
// ALU result stage: two-entry skid buffer between the ALU and register writeback, with NZCV commit.
// Latency: one cycle from input handshake to out_valid when main is empty or committing.
// Backpressure: in_ready is registered (low only while skid holds an entry); outputs hold while !out_ready.
module alu_result_stage #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] resultado,
    input  logic [3:0]   flagsResult,
    input  logic [2:0]   ALUControl,
    input  logic         set_flags,
    input  logic [3:0]   rd,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic [3:0]   out_rd,
    output logic         out_we,
    output logic [3:0]   flags,
    output logic         illegal_op
);

    typedef struct packed {
        logic [N-1:0] result;
        logic [3:0]   nzcv;
        logic [2:0]   op;
        logic         sf;
        logic [3:0]   rd;
    } entry_t;

    localparam logic [2:0] OP_LAST_LEGAL = 3'd5;

    entry_t main_dat;
    entry_t skid_dat;
    entry_t in_dat;
    logic   main_vld;
    logic   skid_vld;
    logic   in_fire;
    logic   out_fire;
    logic   main_legal;

    assign in_dat     = '{result: resultado, nzcv: flagsResult, op: ALUControl,
                          sf: set_flags, rd: rd};
    // skid_vld is a flop, so in_ready is registered and independent of this cycle's handshakes.
    assign in_ready   = ~skid_vld;
    assign in_fire    = in_valid & in_ready;
    assign out_fire   = main_vld & out_ready;
    assign main_legal = (main_dat.op <= OP_LAST_LEGAL);

    assign out_valid  = main_vld;
    assign out_result = main_dat.result;
    assign out_rd     = main_dat.rd;
    assign out_we     = main_vld & main_legal;

    always_ff @(posedge clk) begin
        if (!rst) begin
            main_vld   <= 1'b0;
            skid_vld   <= 1'b0;
            main_dat   <= '0;
            skid_dat   <= '0;
            flags      <= 4'b0000;
            illegal_op <= 1'b0;
        end else if (flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else begin
            if (out_fire) begin
                if (main_legal && main_dat.sf)
                    flags <= main_dat.nzcv;
                if (!main_legal)
                    illegal_op <= 1'b1;
                // in_fire cannot coincide with skid_vld, so skid refills main alone.
                if (skid_vld) begin
                    main_dat <= skid_dat;
                    skid_vld <= 1'b0;
                end else if (in_fire) begin
                    main_dat <= in_dat;
                end else begin
                    main_vld <= 1'b0;
                end
            end else if (in_fire) begin
                if (!main_vld) begin
                    main_dat <= in_dat;
                    main_vld <= 1'b1;
                end else begin
                    skid_dat <= in_dat;
                    skid_vld <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: streaming, backpressure, flag gating, illegal ops, flush, reset.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] resultado;
    logic [3:0]  flagsResult;
    logic [2:0]  ALUControl;
    logic        set_flags;
    logic [3:0]  rd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_rd;
    logic        out_we;
    logic [3:0]  flags;
    logic        illegal_op;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.N(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .resultado(resultado), .flagsResult(flagsResult), .ALUControl(ALUControl),
        .set_flags(set_flags), .rd(rd), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_we(out_we),
        .flags(flags), .illegal_op(illegal_op)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic [3:0] f,
                         input logic [2:0] op, input logic sf, input logic [3:0] d);
        in_valid    = v;
        resultado   = r;
        flagsResult = f;
        ALUControl  = op;
        set_flags   = sf;
        rd          = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ov"},  32'(out_valid),  32'd0);
        chk({tag, "_ir"},  32'(in_ready),   32'd1);
        chk({tag, "_fl"},  32'(flags),      32'd0);
        chk({tag, "_il"},  32'(illegal_op), 32'd0);
        chk({tag, "_we"},  32'(out_we),     32'd0);
        chk({tag, "_res"}, out_result,      32'd0);
        chk({tag, "_rd"},  32'(out_rd),     32'd0);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 3'd0, 1'b0, 4'h0);
        step(); step();
        chk_reset_state("reset");
        rst = 1'b1;
        step();

        // Streaming: add then sub on consecutive cycles.
        out_ready = 1'b1;
        drive(1'b1, 32'h0000_0005, 4'b0000, 3'd0, 1'b1, 4'd1);
        step();
        chk("st_ov0", 32'(out_valid), 32'd1);
        chk("st_res0", out_result, 32'h0000_0005);
        chk("st_rd0", 32'(out_rd), 32'd1);
        drive(1'b1, 32'hFFFF_FFFF, 4'b1000, 3'd1, 1'b1, 4'd2);
        step();
        chk("st_res1", out_result, 32'hFFFF_FFFF);
        chk("st_fl1", 32'(flags), 32'b0000);
        drive(1'b0, 32'h0, 4'h0, 3'd0, 1'b0, 4'h0);
        step();
        chk("st_ov2", 32'(out_valid), 32'd0);
        chk("st_fl2", 32'(flags), 32'b1000);

        // Backpressure: A in main, B in skid, C held upstream.
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 4'h0, 3'd0, 1'b0, 4'd3);
        step();
        chk("bp_ir_a", 32'(in_ready), 32'd1);
        drive(1'b1, 32'hB, 4'h0, 3'd0, 1'b0, 4'd4);
        step();
        chk("bp_ir_b", 32'(in_ready), 32'd0);
        chk("bp_res_a", out_result, 32'hA);
        drive(1'b1, 32'hC, 4'h0, 3'd0, 1'b0, 4'd5);
        step();
        chk("bp_hold_res", out_result, 32'hA);
        chk("bp_hold_rd", 32'(out_rd), 32'd3);
        chk("bp_hold_ir", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        chk("bp_res_b", out_result, 32'hB);
        chk("bp_ir_after", 32'(in_ready), 32'd1);
        step();
        chk("bp_res_c", out_result, 32'hC);
        chk("bp_rd_c", 32'(out_rd), 32'd5);
        drive(1'b0, 32'h0, 4'h0, 3'd0, 1'b0, 4'h0);
        step();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Flag gating: mov without set_flags, then div with set_flags.
        drive(1'b1, 32'h0, 4'b0100, 3'd5, 1'b0, 4'd6);
        step();
        chk("fg_mov_we", 32'(out_we), 32'd1);
        drive(1'b0, 32'h0, 4'h0, 3'd0, 1'b0, 4'h0);
        step();
        chk("fg_mov_fl", 32'(flags), 32'b1000);
        drive(1'b1, 32'h0, 4'b0100, 3'd3, 1'b1, 4'd7);
        step();
        chk("fg_div_we", 32'(out_we), 32'd1);
        drive(1'b0, 32'h0, 4'h0, 3'd0, 1'b0, 4'h0);
        step();
        chk("fg_div_fl", 32'(flags), 32'b0100);

        // Illegal op, then ten ordinary commits.
        drive(1'b1, 32'h1234, 4'b1111, 3'd7, 1'b1, 4'd8);
        step();
        chk("il_ov", 32'(out_valid), 32'd1);
        chk("il_we", 32'(out_we), 32'd0);
        drive(1'b1, 32'h1, 4'b0011, 3'd0, 1'b0, 4'd9);
        step();
        chk("il_fl", 32'(flags), 32'b0100);
        chk("il_set", 32'(illegal_op), 32'd1);
        for (int i = 0; i < 9; i++) step();
        drive(1'b0, 32'h0, 4'h0, 3'd0, 1'b0, 4'h0);
        step();
        chk("il_sticky", 32'(illegal_op), 32'd1);
        chk("il_fl_end", 32'(flags), 32'b0100);
        chk("il_empty", 32'(out_valid), 32'd0);

        // Flush with both handshakes pending.
        out_ready = 1'b0;
        drive(1'b1, 32'h11, 4'b1111, 3'd0, 1'b1, 4'd1);
        step();
        drive(1'b1, 32'h22, 4'b1111, 3'd0, 1'b1, 4'd2);
        step();
        chk("fl_full", 32'(in_ready), 32'd0);
        flush = 1'b1; out_ready = 1'b1;
        drive(1'b1, 32'h33, 4'b0001, 3'd0, 1'b1, 4'd3);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 3'd0, 1'b0, 4'h0);
        chk("fl_ov", 32'(out_valid), 32'd0);
        chk("fl_ir", 32'(in_ready), 32'd1);
        chk("fl_fl", 32'(flags), 32'b0100);
        step();
        chk("fl_drop", 32'(out_valid), 32'd0);
        chk("fl_fl2", 32'(flags), 32'b0100);

        // Reset mid-stream with flags=1010 and illegal_op=1.
        drive(1'b1, 32'h55, 4'b1010, 3'd0, 1'b1, 4'd4);
        step();
        drive(1'b0, 32'h0, 4'h0, 3'd0, 1'b0, 4'h0);
        step();
        chk("rm_fl", 32'(flags), 32'b1010);
        out_ready = 1'b0;
        drive(1'b1, 32'h66, 4'h0, 3'd0, 1'b0, 4'd5);
        step();
        drive(1'b1, 32'h77, 4'h0, 3'd0, 1'b0, 4'd6);
        step();
        chk("rm_full", 32'(in_ready), 32'd0);
        rst = 1'b0; out_ready = 1'b1; flush = 1'b1;
        step();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 3'd0, 1'b0, 4'h0);
        chk_reset_state("rm");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter: N, 32, datapath width of the ALU result.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 in_valid  in  1  ALU output presented this cycle.
REQ-005 in_ready  out  1  stage can accept an entry this cycle.
REQ-006 resultado  in  N  ALU result.
REQ-007 flagsResult  in  4  ALU flags, bit map [3]=N [2]=Z [1]=C [0]=V.
REQ-008 ALUControl  in  3  op tag: 0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 mov, 6-7 illegal.
REQ-009 set_flags  in  1  entry updates architectural flags at commit.
REQ-010 rd  in  4  destination register index.
REQ-011 flush  in  1  discard all held entries.
REQ-012 out_valid  out  1  writeback entry available.
REQ-013 out_ready  in  1  writeback consumes entry this cycle.
REQ-014 out_result  out  N  committed result.
REQ-015 out_rd  out  4  committed destination index.
REQ-016 out_we  out  1  register-file write enable for the entry; 0 for illegal ops.
REQ-017 flags  out  4  architectural NZCV register, same bit map as flagsResult.
REQ-018 illegal_op  out  1  sticky, set when an illegal-op entry commits.

Function
REQ-019 Storage SHALL be a 2-entry skid buffer (main + skid), each entry holding result, flags, op, set_flags, rd.
REQ-020 Input handshake SHALL fire when in_valid && in_ready at a rising edge.
REQ-021 Output handshake SHALL fire when out_valid && out_ready at a rising edge; the main entry is then committed.
REQ-022 in_ready SHALL be a registered signal, 1 when skid is empty, independent of in_valid and out_ready.
REQ-023 Latency SHALL be one cycle: entry accepted at edge k is visible on outputs after edge k if main was empty or committing at k.
REQ-024 Throughput SHALL be one entry per cycle while out_ready is held high.
REQ-025 When main is full and not committing, an accepted entry SHALL go to skid; in_ready drops after that edge.
REQ-026 On commit with skid full, skid SHALL move to main and skid becomes empty in the same edge.
REQ-027 Order SHALL be strict FIFO; no entry duplicated or dropped except by flush.
REQ-028 Output fields SHALL hold stable while out_valid && !out_ready.
REQ-029 out_we SHALL equal out_valid && ALUControl(main) <= 5.
REQ-030 At commit with set_flags=1 and legal op, flags SHALL load the entry's flag nibble; otherwise flags unchanged.
REQ-031 At commit of an illegal op, illegal_op SHALL set to 1 and remain 1 until reset.
REQ-032 flush=1 SHALL empty both entries at that edge; in_ready=1 and out_valid=0 afterward.
REQ-033 flush SHALL take priority over simultaneous input and output handshakes: the incoming entry is dropped and the committing entry does not update flags or illegal_op.
REQ-034 Occupancy SHALL never exceed 2; input with skid full is impossible because in_ready=0.

Reset
REQ-035 With rst=0 at an edge, both entries SHALL be emptied: out_valid=0, in_ready=1, flags=4'b0000, illegal_op=0, out_we=0, out_result=0, out_rd=0.
REQ-036 Reset SHALL override flush and both handshakes in the same cycle; entries in flight are lost.

Verification
REQ-037 Streaming: out_ready=1; send add result 0x00000005 flags 0000 set_flags=1, then sub result 0xFFFFFFFF flags 1000 set_flags=1 -> out_result 5 then 0xFFFFFFFF on consecutive cycles, flags ends 1000.
REQ-038 Backpressure: out_ready=0; send results 0xA, 0xB, 0xC -> 0xA in main, 0xB in skid, in_ready=0, 0xC held upstream; raise out_ready -> commits 0xA, 0xB, 0xC in order, no loss.
REQ-039 Flag gating: commit mov result 0 flags 0100 set_flags=0 -> flags unchanged, out_we=1; then div result 0 flags 0100 set_flags=1 -> flags=0100.
REQ-040 Illegal op: commit ALUControl=7 set_flags=1 flags 1111 -> out_we=0, flags unchanged, illegal_op=1 and stays 1 over 10 further commits.
REQ-041 Flush: two entries held, flush=1 with in_valid=1 and out_ready=1 same cycle -> next cycle out_valid=0, in_ready=1, flags unchanged.
REQ-042 Reset mid-stream: two entries held, flags=1010, illegal_op=1, rst=0 one edge -> all outputs at REQ-035 values.
